ssd_seq_driver: RTL and testbench
=================================

Name: ssd_seq_driver

Overview:
- Parametrised, sequential successor to the combinational decimal seven-segment decoder.
- Converts a WIDTH-bit binary value to DIGITS decimal digits using iterative double-dabble, one bit per clock, instead of a divide/modulo per digit.
- Adds a load/done handshake, output latching, optional signed display with a minus sign, leading-zero blanking, and overflow indication.
- Sits between the datapath register being observed and the board's active-low HEX displays.

Parameters:
- WIDTH, 32, bit width of the input value; WIDTH ≥ 4.
- DIGITS, 8, number of seven-segment digits driven; 1 ≤ DIGITS ≤ 10.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- number  in  WIDTH  value to display; sampled only when a load is accepted.
- load  in  1  request conversion of number; accepted only in IDLE.
- signed_mode  in  1  sampled with number; 1 means number is two's complement.
- blank_lz  in  1  sampled with number; 1 means blank leading zeros.
- busy  out  1  high from the cycle after an accepted load until done.
- done  out  1  one-cycle pulse in the cycle the new hex_out value becomes visible.
- overflow  out  1  high while the displayed value does not fit in DIGITS.
- hex_out  out  7*DIGITS  segments, active-low; digit i occupies [7i+6:7i]; bit order a..g from MSB to LSB.

Behaviour:
- Reset, asynchronous: state=IDLE; busy=0; done=0; overflow=0; every digit=1111111 (blank). A reset mid-conversion aborts it, and no done pulse follows.
- Segment codes:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100
  - blank=1111111, minus=1111110
- FSM states IDLE, CONVERT, ENCODE.
- IDLE:
  - When load=1, capture the mode bits.
  - Capture magnitude: number as-is, or its two's-complement negation if signed_mode=1 and number[WIDTH-1]=1; set neg flag.
  - Clear the BCD register (4*DIGITS bits), clear the internal ovf flag, set bit counter to WIDTH-1, go to CONVERT.
  - load is ignored in every other state; no queueing.
- CONVERT, one magnitude bit per cycle, MSB first:
  - Add 3 to each BCD nibble ≥ 5, then shift left one bit, bringing in the next magnitude bit.
  - Any 1 shifted out of the top nibble sets ovf (sticky).
  - After WIDTH cycles go to ENCODE.
- Magnitude width: the magnitude is treated as an unsigned WIDTH-bit value, so the most negative input converts correctly.
- ENCODE, one cycle:
  - Build all digits and register hex_out and overflow together, assert done, return to IDLE.
  - Leading-zero blanking: digit 0 is never blanked; a digit above the most significant nonzero digit is blanked when blank_lz=1.
  - Minus sign, neg=1 with blank_lz=1: the minus goes in the first digit above the most significant nonzero digit.
  - Minus sign, neg=1 with blank_lz=0: the minus goes in digit DIGITS-1.
  - Overflow: if that minus position's digit is nonzero, or its index ≥ DIGITS, set overflow.
  - If ovf or the minus condition holds: overflow=1 and every digit=1111110; otherwise overflow=0.
- Latency: load accepted at edge N; busy=1 for edges N+1..N+WIDTH+1; hex_out updates and done=1 after edge N+WIDTH+1, i.e. WIDTH+2 cycles from load to display. busy drops in the cycle done is high.
- hex_out, overflow, and the mode bits hold their last values between conversions. Changing number/signed_mode/blank_lz while busy has no effect.
- A load asserted in the same cycle that done is high is accepted, since the state is already IDLE.

Test Plan (WIDTH=32, DIGITS=8):
- Reset: assert rst mid-conversion of 99 → immediately every digit=1111111, busy=0, overflow=0; no done pulse over the next 40 cycles.
- Full display: load number=12345678 unsigned, blank_lz=0 → done exactly 34 cycles after load. hex0=0000000 (8), hex7=1001111 (1), overflow=0.
- Blanking:
  - load 42, blank_lz=1 → hex0=0010010, hex1=1001100, hex2..7=1111111.
  - load 0, blank_lz=1 → hex0=0000001, rest blank.
- Signed:
  - load 0xFFFFFFFB, signed_mode=1, blank_lz=1 → hex0=0100100 (5), hex1=1111110, rest blank.
  - Same with blank_lz=0 → hex0=5, hex1..6=0000001, hex7=1111110.
- Overflow:
  - load 100000000 unsigned → overflow=1, all digits 1111110.
  - load 0x80000000 signed → overflow=1.
  - Then load 7 → overflow=0, hex0=0001111.
- Handshake: pulse load with 5 while busy from a prior load of 9 → 5 is never displayed; exactly one done pulse occurs, showing 9. A load issued in the done cycle is accepted.

Source files
------------

// File: rtl/ssd_seq_driver.sv
// -----------------------------------------------------------------------------
// ssd_seq_driver
//
// Sequential binary-to-decimal seven-segment driver. A WIDTH-bit value is
// converted to DIGITS BCD digits by iterative double-dabble, one magnitude bit
// per clock. The result is then encoded onto active-low HEX displays, with
// optional two's-complement sign display, leading-zero blanking and overflow
// indication.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   number       value to display, sampled when a load is accepted
//   load         conversion request, accepted only in IDLE
//   signed_mode  sampled with number; 1 = number is two's complement
//   blank_lz     sampled with number; 1 = blank leading zeros
//   busy         conversion in progress
//   done         one-cycle pulse when a new hex_out becomes visible
//   overflow     displayed value does not fit in DIGITS
//   hex_out      7*DIGITS segments, active-low; digit i at [7i+6:7i], a..g MSB..LSB
// -----------------------------------------------------------------------------
module ssd_seq_driver #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      number,
    input  logic                  load,
    input  logic                  signed_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_ENCODE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [WIDTH-1:0]      r_mag;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [CW-1:0]         r_cnt;
    logic                  r_neg;
    logic                  r_blank_lz;
    logic                  r_ovf;
    logic                  r_done;
    logic                  r_overflow;
    logic [7*DIGITS-1:0]   r_hex;

    logic [4*DIGITS-1:0]   w_adj;
    logic [3:0]            w_msd;
    logic [3:0]            w_pos;
    logic                  w_minus_ovf;
    logic                  w_overflow;
    logic [7*DIGITS-1:0]   w_hex;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b0000001;
            4'd1:    seg_code = 7'b1001111;
            4'd2:    seg_code = 7'b0010010;
            4'd3:    seg_code = 7'b0000110;
            4'd4:    seg_code = 7'b1001100;
            4'd5:    seg_code = 7'b0100100;
            4'd6:    seg_code = 7'b0100000;
            4'd7:    seg_code = 7'b0001111;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0001100;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves the output unassigned
        // (which would infer a latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (load) w_next_state = S_CONVERT;
            S_CONVERT: if (r_cnt == '0) w_next_state = S_ENCODE;
            S_ENCODE:  w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ double-dabble
    // Add-3 correction of every nibble that would reach 10 or more after the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // ------------------------------------------------------------ encode
    always_comb begin
        w_msd       = '0;
        w_minus_ovf = 1'b0;
        w_hex       = '0;
        // Highest nonzero digit; an all-zero value behaves as if digit 0 were it.
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) w_msd = 4'(i);
        end
        w_pos = r_blank_lz ? (w_msd + 4'd1) : 4'(DIGITS - 1);
        if (r_neg) begin
            if (int'(w_pos) >= DIGITS) w_minus_ovf = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                if (int'(w_pos) == i && r_bcd[4*i +: 4] != 4'd0) w_minus_ovf = 1'b1;
            end
        end
        w_overflow = r_ovf | w_minus_ovf;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_overflow)
                w_hex[7*i +: 7] = SEG_MINUS;
            else if (r_neg && int'(w_pos) == i)
                w_hex[7*i +: 7] = SEG_MINUS;
            else if (r_blank_lz && i > int'(w_msd))
                w_hex[7*i +: 7] = SEG_BLANK;
            else
                w_hex[7*i +: 7] = seg_code(r_bcd[4*i +: 4]);
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mag      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_blank_lz <= 1'b0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_hex      <= {7*DIGITS{1'b1}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_blank_lz <= blank_lz;
                        // Magnitude is unsigned WIDTH bits, so the most
                        // negative input negates to itself and still converts.
                        if (signed_mode && number[WIDTH-1]) begin
                            r_mag <= -number;
                            r_neg <= 1'b1;
                        end else begin
                            r_mag <= number;
                            r_neg <= 1'b0;
                        end
                        r_bcd <= '0;
                        r_ovf <= 1'b0;
                        r_cnt <= CW'(WIDTH - 1);
                    end
                end
                S_CONVERT: begin
                    r_bcd <= {w_adj[4*DIGITS-2:0], r_mag[WIDTH-1]};
                    r_mag <= {r_mag[WIDTH-2:0], 1'b0};
                    // A 1 leaving the top nibble means more digits than DIGITS.
                    r_ovf <= r_ovf | w_adj[4*DIGITS-1];
                    r_cnt <= r_cnt - 1'b1;
                end
                S_ENCODE: begin
                    r_hex      <= w_hex;
                    r_overflow <= w_overflow;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign overflow = r_overflow;
    assign hex_out  = r_hex;

endmodule

// File: tb/tb_ssd_seq_driver.sv
// -----------------------------------------------------------------------------
// tb_ssd_seq_driver
//
// Directed bench for ssd_seq_driver (WIDTH=32, DIGITS=8). Expected segment
// patterns are written out by hand from the digit code table.
// -----------------------------------------------------------------------------
module tb_ssd_seq_driver;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 8;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0001100;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SM = 7'b1111110;

    localparam logic [55:0] ALL_BLANK = {8{SB}};
    localparam logic [55:0] ALL_MINUS = {8{SM}};

    logic                 clk = 1'b0;
    logic                 rst;
    logic [WIDTH-1:0]     number;
    logic                 load;
    logic                 signed_mode;
    logic                 blank_lz;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic [7*DIGITS-1:0]  hex_out;

    int errors = 0;
    int checks = 0;
    int lat;
    int dones;

    ssd_seq_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .number      (number),
        .load        (load),
        .signed_mode (signed_mode),
        .blank_lz    (blank_lz),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .hex_out     (hex_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Issue one load and wait (bounded) for done; lat = edges from the
    // accepting edge (counted as 1) to the edge that raises done, 0 on timeout.
    task automatic run_load(input logic [31:0] num, input logic s, input logic b,
                            output int lat_o);
        @(posedge clk); #1;
        number = num; signed_mode = s; blank_lz = b; load = 1'b1;
        lat_o = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (n == 1) load = 1'b0;
            if (done) begin
                lat_o = n;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; number = '0; load = 1'b0; signed_mode = 1'b0; blank_lz = 1'b0;
        #12;
        check("rst_hex", 64'(hex_out), 64'(ALL_BLANK));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Full 8-digit display, latency
        run_load(32'd12345678, 1'b0, 1'b0, lat);
        check("full_lat", 64'(lat), 64'd34);
        check("full_hex", 64'(hex_out), 64'({S1, S2, S3, S4, S5, S6, S7, S8}));
        check("full_ovf", 64'(overflow), 64'd0);
        check("full_busy_at_done", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);

        // Leading-zero blanking
        run_load(32'd42, 1'b0, 1'b1, lat);
        check("b42_lat", 64'(lat), 64'd34);
        check("b42_hex", 64'(hex_out), 64'({SB, SB, SB, SB, SB, SB, S4, S2}));
        run_load(32'd0, 1'b0, 1'b1, lat);
        check("b0_hex", 64'(hex_out), 64'({SB, SB, SB, SB, SB, SB, SB, S0}));

        // Signed display
        run_load(32'hFFFF_FFFB, 1'b1, 1'b1, lat);
        check("neg5_blz_hex", 64'(hex_out), 64'({SB, SB, SB, SB, SB, SB, SM, S5}));
        check("neg5_blz_ovf", 64'(overflow), 64'd0);
        run_load(32'hFFFF_FFFB, 1'b1, 1'b0, lat);
        check("neg5_full_hex", 64'(hex_out), 64'({SM, S0, S0, S0, S0, S0, S0, S5}));

        // Overflow cases
        run_load(32'd100000000, 1'b0, 1'b0, lat);
        check("ovf9_flag", 64'(overflow), 64'd1);
        check("ovf9_hex", 64'(hex_out), 64'(ALL_MINUS));
        repeat (3) @(posedge clk);
        #1;
        check("ovf_hold", 64'(overflow), 64'd1);
        run_load(32'h8000_0000, 1'b1, 1'b0, lat);
        check("ovfmin_flag", 64'(overflow), 64'd1);
        check("ovfmin_hex", 64'(hex_out), 64'(ALL_MINUS));
        run_load(32'd7, 1'b0, 1'b1, lat);
        check("clr_ovf", 64'(overflow), 64'd0);
        check("clr_hex", 64'(hex_out), 64'({SB, SB, SB, SB, SB, SB, SB, S7}));

        // Load while busy is ignored: exactly one done, showing 9
        @(posedge clk); #1;
        number = 32'd9; signed_mode = 1'b0; blank_lz = 1'b1; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_mid", 64'(busy), 64'd1);
        number = 32'd5; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; number = 32'd0;
        dones = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                check("busy_load_hex", 64'(hex_out), 64'({SB, SB, SB, SB, SB, SB, SB, S9}));
            end
        end
        check("busy_load_dones", 64'(dones), 64'd1);

        // Load in the done cycle is accepted
        run_load(32'd1, 1'b0, 1'b1, lat);
        check("pre_done_seen", 64'(done), 64'd1);
        number = 32'd3; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        check("done_cycle_busy", 64'(busy), 64'd1);
        lat = 0;
        for (int n = 2; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check("done_cycle_lat", 64'(lat), 64'd34);
        check("done_cycle_hex", 64'(hex_out), 64'({SB, SB, SB, SB, SB, SB, SB, S3}));

        // Reset mid-conversion
        @(posedge clk); #1;
        number = 32'd99; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_hex", 64'(hex_out), 64'(ALL_BLANK));
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ovf", 64'(overflow), 64'd0);
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
